// File: rtl/nibble_packer_pkg.sv
// nibble_packer_pkg: shared nibble width and packer FSM state type
package nibble_packer_pkg;
  localparam int NIBBLE_W = 4;
  typedef enum logic {EMPTY, FILL} state_t;
endpackage

// File: rtl/nibble_fifo.sv
// nibble_fifo: DEPTH-entry sync FIFO; push/din in, pop in, dout head, full and occ out, async active-low reset
module nibble_fifo
  import nibble_packer_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter type entry_t = logic
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  entry_t                     din,
  input  logic                       pop,
  output entry_t                     dout,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] occ
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int OW = $clog2(DEPTH+1);
  entry_t mem_q [DEPTH];
  entry_t mem_d [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [OW-1:0] occ_q, occ_d;
  logic do_push, do_pop;
  always_comb begin
    do_push = push && !full;
    do_pop = pop && occ_q != '0;
    mem_d = mem_q;
    if (do_push) mem_d[wr_q] = din;
    wr_d = do_push ? (wr_q == PW'(DEPTH-1) ? '0 : wr_q + 1'b1) : wr_q;
    rd_d = do_pop ? (rd_q == PW'(DEPTH-1) ? '0 : rd_q + 1'b1) : rd_q;
    occ_d = occ_q + OW'(do_push) - OW'(do_pop);
  end
  assign full = occ_q == OW'(DEPTH);
  assign occ = occ_q;
  assign dout = mem_q[rd_q];
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q <= '{default: '0};
      wr_q <= '0;
      rd_q <= '0;
      occ_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      occ_q <= occ_d;
    end
  end
endmodule

// File: rtl/nibble_packer.sv
// nibble_packer: packs 4-bit in_data (valid/ready, in_last) LSB-first into words streamed out via out_valid/out_ready with count, last and word_count
module nibble_packer
  import nibble_packer_pkg::*;
#(
  parameter int NIBBLES = 4,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NIBBLE_W-1:0]          in_data,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NIBBLE_W*NIBBLES-1:0]  out_data,
  output logic [$clog2(NIBBLES+1)-1:0] out_count,
  output logic                         out_last,
  output logic [7:0]                   word_count
);
  localparam int W = NIBBLE_W*NIBBLES;
  localparam int KW = $clog2(NIBBLES);
  localparam int CW = $clog2(NIBBLES+1);
  typedef logic [W-1:0] word_t;
  typedef struct packed {
    word_t         data;
    logic [CW-1:0] count;
    logic          last;
  } entry_t;
  state_t state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  word_t word_q, word_d, wr_word;
  logic [7:0] wc_q, wc_d;
  logic ready_q, acc, commit, full;
  entry_t push_e, head;
  logic [$clog2(DEPTH+1)-1:0] occ;
  always_comb begin
    acc = in_valid && in_ready;
    commit = acc && (in_last || k_q == KW'(NIBBLES-1));
    wr_word = word_q | (word_t'(in_data) << (NIBBLE_W*k_q));
    push_e = '{data: wr_word, count: CW'(k_q) + CW'(1), last: in_last};
    state_d = commit ? EMPTY : acc ? FILL : state_q;
    k_d = commit ? '0 : acc ? k_q + 1'b1 : k_q;
    word_d = commit ? '0 : acc ? wr_word : word_q;
    wc_d = wc_q + 8'(out_valid && out_ready);
  end
  // ready_q holds in_ready low until the first edge after reset release
  assign in_ready = ready_q && !full;
  assign out_valid = occ != '0;
  assign out_data = head.data;
  assign out_count = head.count;
  assign out_last = head.last;
  assign word_count = wc_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= EMPTY;
      k_q <= '0;
      word_q <= '0;
      wc_q <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      word_q <= word_d;
      wc_q <= wc_d;
      ready_q <= 1'b1;
    end
  end
  nibble_fifo #(.DEPTH(DEPTH), .entry_t(entry_t)) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (commit),
    .din  (push_e),
    .pop  (out_valid && out_ready),
    .dout (head),
    .full (full),
    .occ  (occ)
  );
endmodule
